// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a winner keeps the grant for max(weight,1) acked beats.
// Zero-cycle grant from registered rotation/lock state; ack_i advances the state.
module wrr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] weight_i,
  input  logic                     ack_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     gnt_vld_o,
  output logic [IDX_W-1:0]         gnt_idx_o,
  output logic                     locked_o
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;

  logic [CNT_W-1:0] w_arr [NUM_REQ];
  logic             locked_mode;
  logic [IDX_W-1:0] base;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] win_w;
  int               cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wt
    assign w_arr[g] = weight_i[g*CNT_W +: CNT_W];
  end

  assign locked_mode = lock_q && req_i[owner_q];

  // An abandoning owner searches from its own index so it never regrants ahead of others.
  always_comb begin
    base      = lock_q ? owner_q : last_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(base) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_w = (w_arr[win_idx] == '0) ? CNT_W'(1) : w_arr[win_idx];

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    if (locked_mode) begin
      if (ack_i) begin
        if (cnt_q == CNT_W'(1)) begin
          lock_d = 1'b0;
          cnt_d  = '0;
          last_d = owner_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end else begin
      if (lock_q) begin
        lock_d = 1'b0;
        cnt_d  = '0;
        last_d = owner_q;
      end
      if (win_found && ack_i) begin
        if (win_w == CNT_W'(1)) begin
          last_d = win_idx;
          lock_d = 1'b0;
        end else begin
          owner_d = win_idx;
          cnt_d   = win_w - CNT_W'(1);
          lock_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    gnt_vld_o = !reset && (locked_mode || win_found);
    locked_o  = !reset && locked_mode;
    gnt_idx_o = '0;
    if (!reset) begin
      if (locked_mode)    gnt_idx_o = owner_q;
      else if (win_found) gnt_idx_o = win_idx;
    end
    gnt_o = gnt_vld_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios plus random traffic against a tenure-level model.
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*CW-1:0] weight = '0;
  logic          ack = 1'b0;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic          locked;

  int vectors = 0;
  int miscompares = 0;

  // Model: tenure owner (-1 when none), quota and beats taken so far.
  int  m_last, m_owner, m_quota, m_taken;
  int  e_idx;
  bit  e_vld, e_lock;

  wrr_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_i(req), .weight_i(weight), .ack_i(ack),
    .gnt_o(gnt), .gnt_vld_o(gnt_vld), .gnt_idx_o(gnt_idx), .locked_o(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wt(input logic [N*CW-1:0] w, input int i);
    return int'((w >> (i*CW)) & 16'hF);
  endfunction

  task automatic model_eval();
    int start;
    e_vld = 0; e_idx = 0; e_lock = 0;
    if (!reset) begin
      if (m_owner >= 0 && req[m_owner]) begin
        e_vld = 1; e_idx = m_owner; e_lock = 1;
      end else begin
        start = (m_owner >= 0) ? m_owner : m_last;
        for (int k = 1; k <= N; k++)
          if (!e_vld && req[(start + k) % N]) begin
            e_vld = 1; e_idx = (start + k) % N;
          end
      end
    end
  endtask

  task automatic model_update();
    int q;
    if (reset) begin
      m_last = N-1; m_owner = -1; m_quota = 0; m_taken = 0;
    end else if (e_lock) begin
      if (ack) begin
        m_taken++;
        if (m_taken == m_quota) begin m_last = m_owner; m_owner = -1; end
      end
    end else begin
      if (m_owner >= 0) begin m_last = m_owner; m_owner = -1; end
      if (e_vld && ack) begin
        q = wt(weight, e_idx);
        if (q == 0) q = 1;
        if (q == 1) m_last = e_idx;
        else begin m_owner = e_idx; m_quota = q; m_taken = 1; end
      end
    end
  endtask

  // One cycle: drive, check mid-cycle against model (and optional explicit values), clock.
  task automatic step(input logic [N-1:0] r, input logic [N*CW-1:0] w, input logic a,
                      input logic rs, input int exp_g = -1, input int exp_l = -1);
    req = r; weight = w; ack = a; reset = rs;
    #2;
    model_eval();
    chk("gnt",  32'(gnt),     e_vld ? (32'd1 << e_idx) : 32'd0);
    chk("vld",  32'(gnt_vld), 32'(e_vld));
    chk("idx",  32'(gnt_idx), 32'(e_idx));
    chk("lock", 32'(locked),  32'(e_lock));
    if (exp_g >= 0) chk("gnt_dir",  32'(gnt),    32'(exp_g));
    if (exp_l >= 0) chk("lock_dir", 32'(locked), 32'(exp_l));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    m_last = N-1; m_owner = -1; m_quota = 0; m_taken = 0;

    // Plain round robin, all weights 1.
    step(4'b0000, 16'h1111, 1'b0, 1'b1, 0, 0);
    step(4'b0000, 16'h1111, 1'b0, 1'b0, 0, 0);
    step(4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0001, 0);
    step(4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0010, 0);
    step(4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0100, 0);
    step(4'b1111, 16'h1111, 1'b1, 1'b0, 4'b1000, 0);
    step(4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0001, 0);

    // w0=2, w2=3.
    step(4'b0000, 16'h1312, 1'b0, 1'b1, 0, 0);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0001, 0);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0001, 1);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0100, 0);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0100, 1);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0100, 1);
    step(4'b0101, 16'h1312, 1'b1, 1'b0, 4'b0001, 0);

    // Zero weights behave as 1.
    step(4'b0000, 16'h0000, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++)
      step(4'b1010, 16'h0000, 1'b1, 1'b0, (i % 2 == 0) ? 4'b0010 : 4'b1000, 0);

    // Owner 1 (weight 4) abandons after one beat.
    step(4'b0000, 16'h1141, 1'b0, 1'b1, 0, 0);
    step(4'b0010, 16'h1141, 1'b1, 1'b0, 4'b0010, 0);
    step(4'b1001, 16'h1141, 1'b1, 1'b0, 4'b1000, 0);
    step(4'b1001, 16'h1141, 1'b1, 1'b0, 4'b0001, 0);

    // Weight-3 tenure held by ack=0 while req0 rises.
    step(4'b0000, 16'h1311, 1'b0, 1'b1, 0, 0);
    step(4'b0100, 16'h1311, 1'b1, 1'b0, 4'b0100, 0);
    for (int i = 0; i < 5; i++)
      step(4'b0101, 16'h1F11, 1'b0, 1'b0, 4'b0100, 1);
    step(4'b0101, 16'h1F11, 1'b1, 1'b0, 4'b0100, 1);
    step(4'b0101, 16'h1F11, 1'b1, 1'b0, 4'b0100, 1);
    step(4'b0101, 16'h1F11, 1'b1, 1'b0, 4'b0001, 0);

    // Reset mid-tenure (owner 3, two beats left).
    step(4'b0000, 16'h3111, 1'b0, 1'b1, 0, 0);
    step(4'b1000, 16'h3111, 1'b1, 1'b0, 4'b1000, 0);
    step(4'b1001, 16'h3111, 1'b1, 1'b1, 0, 0);
    step(4'b1001, 16'h3111, 1'b0, 1'b0, 4'b0001, 0);

    // Maximum weight: 15 consecutive beats.
    step(4'b0000, 16'h111F, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 15; i++)
      step(4'b0011, 16'h111F, 1'b1, 1'b0, 4'b0001, (i == 0) ? 0 : 1);
    step(4'b0011, 16'h111F, 1'b1, 1'b0, 4'b0010, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(N'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
